// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response channels and MainMemory bus of the memory access controller.
// The controller takes the master modport; the core and memory side take slave.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_valid;
  logic [DATA_W-1:0] if_data;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_ready;
  logic              ls_valid;
  logic [DATA_W-1:0] ls_rdata;
  logic              align_err;
  logic              memread;
  logic              memwrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, data_out,
    output if_ready, if_valid, if_data, ls_ready, ls_valid, ls_rdata, align_err,
    output memread, memwrite, address, data_in
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, data_out,
    input  if_ready, if_valid, if_data, ls_ready, ls_valid, ls_rdata, align_err,
    input  memread, memwrite, address, data_in
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Arbitrates instruction-fetch and load/store requests onto single-ported MainMemory,
// running one access of WAIT_CYCLES+1 cycles at a time and returning data or a write ack.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  mem_access_ctrl_if.master bus
);

  typedef enum logic {StIdle, StAccess} state_e;

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              src_ls_q, src_ls_d;
  logic              we_q, we_d;
  logic              memread_q, memread_d;
  logic              memwrite_q, memwrite_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              ls_valid_q, ls_valid_d;
  logic              align_err_q, align_err_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  logic              idle;
  logic              ls_ready, if_ready;
  logic              accept_ls, accept_if, store;
  logic [ADDR_W-1:0] req_addr;

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign idle      = (state_q == StIdle);
  assign ls_ready  = idle & ~rst;
  assign if_ready  = idle & ~rst & ~bus.ls_req;
  assign accept_ls = bus.ls_req & ls_ready;
  assign accept_if = bus.if_req & if_ready;
  assign store     = accept_ls & bus.ls_we;
  assign req_addr  = accept_ls ? bus.ls_addr : bus.if_addr;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src_ls_d    = src_ls_q;
    we_d        = we_q;
    memread_d   = memread_q;
    memwrite_d  = memwrite_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_valid_d  = 1'b0;
    ls_valid_d  = 1'b0;
    align_err_d = 1'b0;
    if_data_d   = if_data_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      StIdle: begin
        if (accept_ls || accept_if) begin
          if (req_addr[1:0] != 2'b00) begin
            align_err_d = 1'b1;
          end else begin
            state_d    = StAccess;
            cnt_d      = CNT_LOAD;
            src_ls_d   = accept_ls;
            we_d       = store;
            memread_d  = ~store;
            memwrite_d = store;
            addr_d     = req_addr;
            if (store) wdata_d = bus.ls_wdata;
          end
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d    = StIdle;
          memread_d  = 1'b0;
          memwrite_d = 1'b0;
          if (!we_q) begin
            if (src_ls_q) ls_rdata_d = bus.data_out;
            else          if_data_d  = bus.data_out;
          end
          if (src_ls_q) ls_valid_d = 1'b1;
          else          if_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      src_ls_q    <= 1'b0;
      we_q        <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_valid_q  <= 1'b0;
      ls_valid_q  <= 1'b0;
      align_err_q <= 1'b0;
      if_data_q   <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_ls_q    <= src_ls_d;
      we_q        <= we_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_valid_q  <= if_valid_d;
      ls_valid_q  <= ls_valid_d;
      align_err_q <= align_err_d;
      if_data_q   <= if_data_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign bus.if_ready  = if_ready;
  assign bus.ls_ready  = ls_ready;
  assign bus.if_valid  = if_valid_q;
  assign bus.ls_valid  = ls_valid_q;
  assign bus.if_data   = if_data_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.align_err = align_err_q;
  assign bus.memread   = memread_q;
  assign bus.memwrite  = memwrite_q;
  assign bus.address   = addr_q;
  assign bus.data_in   = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: WAIT_CYCLES=1 controller for fetch/store/arbitration/alignment/reset cases,
// plus a WAIT_CYCLES=0 controller for back-to-back fetches, both against a small ROM model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_cnt0 = 0;

  mem_access_ctrl_if #(.ADDR_W(17), .DATA_W(32)) bus0 ();
  mem_access_ctrl_if #(.ADDR_W(17), .DATA_W(32)) bus1 ();

  mem_access_ctrl #(.ADDR_W(17), .DATA_W(32), .WAIT_CYCLES(1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  mem_access_ctrl #(.ADDR_W(17), .DATA_W(32), .WAIT_CYCLES(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [16:0] a);
    case (a)
      17'd0:   rom = 32'h8E08_0200;
      17'd4:   rom = 32'h2009_0004;
      17'd8:   rom = 32'h0109_5020;
      17'd768: rom = 32'hCAFE_F00D;
      default: rom = 32'h0000_0000;
    endcase
  endfunction

  assign bus0.data_out = rom(bus0.address);
  assign bus1.data_out = rom(bus1.address);

  // Counts clock edges at which MainMemory would commit a write.
  always @(posedge clk) if (bus0.memwrite) wr_cnt0 <= wr_cnt0 + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus0.if_req = 0; bus0.if_addr = '0; bus0.ls_req = 0; bus0.ls_we = 0;
    bus0.ls_addr = '0; bus0.ls_wdata = '0;
    bus1.if_req = 0; bus1.if_addr = '0; bus1.ls_req = 0; bus1.ls_we = 0;
    bus1.ls_addr = '0; bus1.ls_wdata = '0;

    // Reset state
    #2;
    check("rst_ls_ready", 32'(bus0.ls_ready), 32'd0);
    check("rst_if_ready", 32'(bus0.if_ready), 32'd0);
    check("rst_memread",  32'(bus0.memread),  32'd0);
    check("rst_memwrite", 32'(bus0.memwrite), 32'd0);
    check("rst_address",  32'(bus0.address),  32'd0);
    check("rst_if_data",  bus0.if_data,       32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // 1: fetch from address 0
    bus0.if_req = 1; bus0.if_addr = 17'd0;
    #1 check("t1_if_ready", 32'(bus0.if_ready), 32'd1);
    cyc();
    bus0.if_req = 0;
    check("t1_memread_c1", 32'(bus0.memread),  32'd1);
    check("t1_memwrite_c1", 32'(bus0.memwrite), 32'd0);
    check("t1_address_c1", 32'(bus0.address),  32'd0);
    cyc();
    check("t1_memread_c2", 32'(bus0.memread),  32'd1);
    check("t1_if_valid_c2", 32'(bus0.if_valid), 32'd0);
    cyc();
    check("t1_if_valid_c3", 32'(bus0.if_valid), 32'd1);
    check("t1_if_data",     bus0.if_data,       32'h8E08_0200);
    check("t1_memread_c3",  32'(bus0.memread),  32'd0);
    check("t1_if_ready_c3", 32'(bus0.if_ready), 32'd1);
    cyc();
    check("t1_if_valid_c4", 32'(bus0.if_valid), 32'd0);

    // 2: store 0x12345678 to 256
    bus0.ls_req = 1; bus0.ls_we = 1; bus0.ls_addr = 17'd256; bus0.ls_wdata = 32'h1234_5678;
    #1 check("t2_ls_ready", 32'(bus0.ls_ready), 32'd1);
    cyc();
    bus0.ls_req = 0; bus0.ls_we = 0;
    check("t2_memwrite_c1", 32'(bus0.memwrite), 32'd1);
    check("t2_memread_c1",  32'(bus0.memread),  32'd0);
    check("t2_address_c1",  32'(bus0.address),  32'd256);
    check("t2_data_in_c1",  bus0.data_in,       32'h1234_5678);
    cyc();
    check("t2_memwrite_c2", 32'(bus0.memwrite), 32'd1);
    check("t2_data_in_c2",  bus0.data_in,       32'h1234_5678);
    cyc();
    check("t2_ls_valid",    32'(bus0.ls_valid), 32'd1);
    check("t2_memwrite_c3", 32'(bus0.memwrite), 32'd0);
    check("t2_ls_rdata",    bus0.ls_rdata,      32'd0);
    check("t2_if_valid",    32'(bus0.if_valid), 32'd0);
    check("t2_write_edges", 32'(wr_cnt0),       32'd2);
    cyc();
    check("t2_ls_valid_c4", 32'(bus0.ls_valid), 32'd0);

    // 3: simultaneous fetch (4) and load (768); load wins
    bus0.if_req = 1; bus0.if_addr = 17'd4;
    bus0.ls_req = 1; bus0.ls_we = 0; bus0.ls_addr = 17'd768;
    #1 check("t3_if_ready", 32'(bus0.if_ready), 32'd0);
    check("t3_ls_ready", 32'(bus0.ls_ready), 32'd1);
    cyc();
    bus0.ls_req = 0;
    check("t3_address_ls", 32'(bus0.address),  32'd768);
    check("t3_memread_ls", 32'(bus0.memread),  32'd1);
    check("t3_if_ready_busy", 32'(bus0.if_ready), 32'd0);
    cyc();
    cyc();
    check("t3_ls_valid",   32'(bus0.ls_valid), 32'd1);
    check("t3_ls_rdata",   bus0.ls_rdata,      32'hCAFE_F00D);
    check("t3_if_valid_early", 32'(bus0.if_valid), 32'd0);
    check("t3_if_ready_c3", 32'(bus0.if_ready), 32'd1);
    cyc();
    bus0.if_req = 0;
    check("t3_address_if", 32'(bus0.address),  32'd4);
    check("t3_memread_if", 32'(bus0.memread),  32'd1);
    cyc();
    cyc();
    check("t3_if_valid",   32'(bus0.if_valid), 32'd1);
    check("t3_if_data",    bus0.if_data,       32'h2009_0004);
    check("t3_ls_rdata_hold", bus0.ls_rdata,   32'hCAFE_F00D);
    cyc();

    // 4: misaligned load, then a normal load
    bus0.ls_req = 1; bus0.ls_we = 0; bus0.ls_addr = 17'h102;
    cyc();
    bus0.ls_req = 0;
    check("t4_align_err",  32'(bus0.align_err), 32'd1);
    check("t4_memread",    32'(bus0.memread),   32'd0);
    check("t4_address_hold", 32'(bus0.address), 32'd4);
    check("t4_ls_ready",   32'(bus0.ls_ready),  32'd1);
    cyc();
    check("t4_align_err_c2", 32'(bus0.align_err), 32'd0);
    check("t4_ls_valid_c2",  32'(bus0.ls_valid),  32'd0);
    bus0.ls_req = 1; bus0.ls_addr = 17'd8;
    #1 check("t4_next_ready", 32'(bus0.ls_ready), 32'd1);
    cyc();
    bus0.ls_req = 0;
    check("t4_next_memread", 32'(bus0.memread), 32'd1);
    cyc();
    cyc();
    check("t4_next_valid", 32'(bus0.ls_valid), 32'd1);
    check("t4_next_rdata", bus0.ls_rdata,      32'h0109_5020);
    cyc();

    // 5: reset during cycle 1 of a store
    bus0.ls_req = 1; bus0.ls_we = 1; bus0.ls_addr = 17'd0; bus0.ls_wdata = 32'hDEAD_BEEF;
    cyc();
    bus0.ls_req = 0; bus0.ls_we = 0;
    check("t5_memwrite_pre", 32'(bus0.memwrite), 32'd1);
    #1 rst = 1;
    #1;
    check("t5_memwrite_rst", 32'(bus0.memwrite), 32'd0);
    check("t5_memread_rst",  32'(bus0.memread),  32'd0);
    check("t5_ls_valid_rst", 32'(bus0.ls_valid), 32'd0);
    check("t5_ls_ready_rst", 32'(bus0.ls_ready), 32'd0);
    cyc();
    rst = 0;
    #1;
    check("t5_ls_ready_post", 32'(bus0.ls_ready), 32'd1);
    check("t5_if_ready_post", 32'(bus0.if_ready), 32'd1);
    check("t5_no_write",      32'(wr_cnt0),       32'd2);
    cyc();
    cyc();
    check("t5_no_valid",      32'(bus0.ls_valid), 32'd0);

    // 6: WAIT_CYCLES=0, back-to-back fetches to 0, 4, 8
    for (int i = 0; i < 3; i++) begin
      bus1.if_req = 1; bus1.if_addr = 17'(4 * i);
      #1 check($sformatf("t6_ready_%0d", i), 32'(bus1.if_ready), 32'd1);
      cyc();
      if (i == 2) bus1.if_req = 0;
      check($sformatf("t6_memread_%0d", i), 32'(bus1.memread),  32'd1);
      check($sformatf("t6_address_%0d", i), 32'(bus1.address),  32'(4 * i));
      check($sformatf("t6_novalid_%0d", i), 32'(bus1.if_valid), 32'd0);
      cyc();
      check($sformatf("t6_valid_%0d", i), 32'(bus1.if_valid), 32'd1);
      check($sformatf("t6_data_%0d", i),  bus1.if_data,       rom(17'(4 * i)));
    end
    cyc();
    check("t6_valid_end", 32'(bus1.if_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
